// File: rtl/register_rename_if.sv
// ----------------------------------------------------------------------------
// register_rename_if
//
// Purpose: bundles the rename stage's decode-side handshake, reorder-buffer
// handshake and retirement free port into one interface.
//
// Parameter:
//   REG_FILE_ADDR_WIDTH  physical register index width (2**W physical regs)
//
// Signals (direction as seen by the rename block, modport "slave"):
//   in_valid, instr_in, rs1_arch, rs2_arch, rd_arch, rd_write   in
//   in_ready                                                    out
//   out_valid, instr_out, rs1_phys, rs2_phys, dest_reg_out,
//   old_reg_out, writes_rd_out                                  out
//   out_ready                                                   in
//   free_en, free_reg                                           in
//   free_count, free_overflow                                   out
// The "master" modport is the mirror image for the decode/ROB side.
// ----------------------------------------------------------------------------
interface register_rename_if #(
    parameter int REG_FILE_ADDR_WIDTH = 7
);
    // Decode side
    logic                           in_valid;
    logic                           in_ready;
    logic [31:0]                    instr_in;
    logic [4:0]                     rs1_arch;
    logic [4:0]                     rs2_arch;
    logic [4:0]                     rd_arch;
    logic                           rd_write;

    // Reorder buffer side
    logic                           out_valid;
    logic                           out_ready;
    logic [31:0]                    instr_out;
    logic [REG_FILE_ADDR_WIDTH-1:0] rs1_phys;
    logic [REG_FILE_ADDR_WIDTH-1:0] rs2_phys;
    logic [REG_FILE_ADDR_WIDTH-1:0] dest_reg_out;
    logic [REG_FILE_ADDR_WIDTH-1:0] old_reg_out;
    logic                           writes_rd_out;

    // Retirement free port and status
    logic                           free_en;
    logic [REG_FILE_ADDR_WIDTH-1:0] free_reg;
    logic [REG_FILE_ADDR_WIDTH:0]   free_count;
    logic                           free_overflow;

    modport master (
        output in_valid, instr_in, rs1_arch, rs2_arch, rd_arch, rd_write,
        input  in_ready,
        input  out_valid, instr_out, rs1_phys, rs2_phys, dest_reg_out,
               old_reg_out, writes_rd_out,
        output out_ready,
        output free_en, free_reg,
        input  free_count, free_overflow
    );

    modport slave (
        input  in_valid, instr_in, rs1_arch, rs2_arch, rd_arch, rd_write,
        output in_ready,
        output out_valid, instr_out, rs1_phys, rs2_phys, dest_reg_out,
               old_reg_out, writes_rd_out,
        input  out_ready,
        input  free_en, free_reg,
        output free_count, free_overflow
    );
endinterface

// File: rtl/register_rename.sv
// ----------------------------------------------------------------------------
// register_rename
//
// Purpose: single-issue register rename stage. Maps architectural operands to
// physical registers through a map table, allocates a fresh destination from
// a circular free list for every instruction that writes a nonzero rd, and
// presents the renamed instruction to the reorder buffer one cycle after it
// is accepted. Registers released at retirement are pushed back onto the
// free list.
//
// Parameters:
//   REG_FILE_ADDR_WIDTH  physical register index width W (2**W regs)
//   ARCH_REGS            architectural register count (index width 5)
//
// Ports:
//   clock   in   sole clock, rising edge
//   reset   in   asynchronous active-low reset
//   bus     register_rename_if.slave (decode handshake, ROB handshake,
//           free port, free_count / free_overflow status)
//
// Optional feature macro: RENAME_FREE_BYPASS_EN
//   When defined, a register being freed in the same cycle that the free
//   list is empty can be handed straight to an allocating instruction
//   instead of going through the list.
// ----------------------------------------------------------------------------
module register_rename #(
    parameter int REG_FILE_ADDR_WIDTH = 7,
    parameter int ARCH_REGS           = 32
) (
    input logic              clock,
    input logic              reset,
    register_rename_if.slave bus
);

    localparam int W        = REG_FILE_ADDR_WIDTH;
    localparam int DEPTH    = 1 << W;
    localparam int MAX_FREE = DEPTH - ARCH_REGS;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [W-1:0]  map_q  [ARCH_REGS];
    logic [W-1:0]  fifo_q [DEPTH];
    logic [W-1:0]  head_q, head_d;
    logic [W-1:0]  tail_q, tail_d;
    logic [W:0]    count_q, count_d;
    logic          overflow_q, overflow_d;

    logic          out_valid_q, out_valid_d;
    logic [31:0]   instr_q, instr_d;
    logic [W-1:0]  rs1_q, rs1_d;
    logic [W-1:0]  rs2_q, rs2_d;
    logic [W-1:0]  dest_q, dest_d;
    logic [W-1:0]  old_q, old_d;
    logic          wr_q, wr_d;

    // ------------------------------------------------------------------
    // Handshake and allocation decisions
    // ------------------------------------------------------------------
    logic          alloc_needed;
    logic          fl_empty;
    logic          fl_full;
    logic          bypass_ok;
    logic          accept;
    logic          pop;
    logic          use_bypass;
    logic          push_req;
    logic          push;
    logic [W-1:0]  dest_sel;

    // x0 is hardwired: it is never renamed and always reads phys 0.
    assign alloc_needed = bus.rd_write && (bus.rd_arch != 5'd0);
    assign fl_empty     = (count_q == '0);
    assign fl_full      = (count_q == (W+1)'(MAX_FREE));

`ifdef RENAME_FREE_BYPASS_EN
    // A register coming back this cycle counts as available when the list
    // itself is empty; it is consumed directly and never enters the list.
    assign bypass_ok = bus.free_en && (bus.free_reg != '0) && fl_empty;
`else
    assign bypass_ok = 1'b0;
`endif

    assign bus.in_ready = (!out_valid_q || bus.out_ready) &&
                          (!alloc_needed || !fl_empty || bypass_ok);

    assign accept     = bus.in_valid && bus.in_ready;
    assign pop        = accept && alloc_needed && !fl_empty;
    assign use_bypass = accept && alloc_needed && fl_empty;

    // A freed register consumed by the bypass path must not also be pushed.
    assign push_req   = bus.free_en && (bus.free_reg != '0) && !use_bypass;
    assign push       = push_req && !fl_full;

    always_comb begin
        dest_sel = '0;
        if (pop) begin
            dest_sel = fifo_q[head_q];
        end else if (use_bypass) begin
            dest_sel = bus.free_reg;
        end
    end

    // ------------------------------------------------------------------
    // Free list pointer / count next state
    // ------------------------------------------------------------------
    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        overflow_d = overflow_q;
        count_d    = count_q + (W+1)'(push) - (W+1)'(pop);
        if (pop) begin
            head_d = head_q + W'(1);
        end
        if (push) begin
            tail_d = tail_q + W'(1);
        end
        // A push into a full list means retirement released a register the
        // list never handed out; flag it and keep the list consistent.
        if (push_req && fl_full) begin
            overflow_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output register next state
    // ------------------------------------------------------------------
    always_comb begin
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        dest_d      = dest_q;
        old_d       = old_q;
        wr_d        = wr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            instr_d     = bus.instr_in;
            // Sources read the map before this instruction's rd update lands.
            rs1_d       = map_q[bus.rs1_arch];
            rs2_d       = map_q[bus.rs2_arch];
            dest_d      = alloc_needed ? dest_sel : '0;
            old_d       = alloc_needed ? map_q[bus.rd_arch] : '0;
            wr_d        = alloc_needed;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Map table: identity after reset
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_q[i] <= W'(i);
            end
        end else if (accept && alloc_needed) begin
            map_q[bus.rd_arch] <= dest_sel;
        end
    end

    // ------------------------------------------------------------------
    // Free list storage: regs ARCH_REGS..DEPTH-1 in ascending order
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= (i < MAX_FREE) ? W'(i + ARCH_REGS) : '0;
            end
        end else if (push) begin
            fifo_q[tail_q] <= bus.free_reg;
        end
    end

    // ------------------------------------------------------------------
    // Free list control
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= W'(MAX_FREE);
            count_q    <= (W+1)'(MAX_FREE);
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Output register (one-cycle rename latency); cleared on reset so a
    // half-delivered instruction is discarded
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            dest_q      <= '0;
            old_q       <= '0;
            wr_q        <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            dest_q      <= dest_d;
            old_q       <= old_d;
            wr_q        <= wr_d;
        end
    end

    assign bus.out_valid     = out_valid_q;
    assign bus.instr_out     = instr_q;
    assign bus.rs1_phys      = rs1_q;
    assign bus.rs2_phys      = rs2_q;
    assign bus.dest_reg_out  = dest_q;
    assign bus.old_reg_out   = old_q;
    assign bus.writes_rd_out = wr_q;
    assign bus.free_count    = count_q;
    assign bus.free_overflow = overflow_q;

endmodule

// File: doc/register_rename.md
REGISTER_RENAME -- requirements
Module: register_rename

Interface
REQ-001 SHALL have parameter REG_FILE_ADDR_WIDTH, default 7, physical register address width (2**W physical regs).
REQ-002 SHALL have parameter ARCH_REGS, default 32, architectural register count; arch index width 5.
REQ-003 SHALL have clock  input  1  sole clock, rising edge.
REQ-004 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have in_valid  input  1  decoded instruction offered.
REQ-006 SHALL have in_ready  output  1  instruction accepted this edge when in_valid high.
REQ-007 SHALL have instr_in  input  32  raw instruction, passed through.
REQ-008 SHALL have rs1_arch, rs2_arch, rd_arch  input  5 each  architectural operands.
REQ-009 SHALL have rd_write  input  1  instruction writes rd.
REQ-010 SHALL have out_valid  output  1  renamed instruction available to reorder buffer.
REQ-011 SHALL have out_ready  input  1  reorder buffer accepts (driven from !full).
REQ-012 SHALL have instr_out  output  32; rs1_phys, rs2_phys, dest_reg_out, old_reg_out  output  W each; writes_rd_out  output  1.
REQ-013 SHALL have free_en  input  1; free_reg  input  W  physical reg released by retirement (old register of retiring instruction).
REQ-014 SHALL have free_count  output  W+1  entries in free list; free_overflow  output  1  sticky error.

Function
REQ-015 SHALL define alloc_needed = rd_write && rd_arch != 0; x0 never renamed, always maps to phys 0.
REQ-016 SHALL drive in_ready = (!out_valid || out_ready) && (!alloc_needed || free_count != 0), purely combinational.
REQ-017 SHALL, on accept (in_valid && in_ready), register at the next edge: out_valid=1, instr_out, rs1_phys=map[rs1_arch], rs2_phys=map[rs2_arch], old_reg_out=map[rd_arch], writes_rd_out=alloc_needed; latency exactly 1 cycle.
REQ-018 SHALL read source mappings before the same instruction's rd update (rs1=rd=x5 returns prior mapping).
REQ-019 SHALL, when alloc_needed on accept, set dest_reg_out=free-list head, pop head, write map[rd_arch]=that reg; otherwise dest_reg_out=0, old_reg_out=0, no pop, no map write.
REQ-020 SHALL hold all out_* stable while out_valid && !out_ready; clear out_valid on out_ready without new accept.
REQ-021 SHALL implement free list as circular FIFO depth 2**W, head/tail wrapping modulo 2**W.
REQ-022 SHALL, on free_en, push free_reg at tail; free_reg 0 ignored.
REQ-023 SHALL, on free_en with free_count == 2**W - ARCH_REGS, drop push and set free_overflow until reset.
REQ-024 SHALL, on simultaneous pop and push, leave free_count unchanged and advance both pointers.
REQ-025 SHALL have free_count = pushes minus pops, never below 0 or above 2**W - ARCH_REGS.

Reset
REQ-026 SHALL on reset low, immediately: out_valid=0, all out_* data=0, free_overflow=0.
REQ-027 SHALL reset map[i]=i for i in 0..31, free list contents 32..2**W-1 in ascending order, head=0, free_count=2**W-32 (96 default).
REQ-028 SHALL discard any in-flight output on reset mid-operation; first accept after release allocates phys 32.

Configuration
REQ-029 SHALL support macro RENAME_FREE_BYPASS_EN.
REQ-030 SHALL, with RENAME_FREE_BYPASS_EN defined, treat free_en with nonzero free_reg as available when free_count==0: in_ready may assert, dest_reg_out=free_reg, no push, free_count stays 0.
REQ-031 SHALL, without RENAME_FREE_BYPASS_EN, block in_ready whenever alloc_needed && free_count==0, regardless of free_en.

Verification
REQ-032 Reset release, accept add x5,x1,x2 -> next cycle rs1_phys=1, rs2_phys=2, dest_reg_out=32, old_reg_out=5, free_count=95.
REQ-033 Back-to-back x5 writes, second reads x5 -> second: rs1_phys=32, dest_reg_out=33, old_reg_out=32.
REQ-034 rd_arch=0 with rd_write=1 -> writes_rd_out=0, dest_reg_out=0, free_count unchanged.
REQ-035 out_ready=0 three cycles with in_valid high -> in_ready=0, outputs held, no pops.
REQ-036 96 allocations with no free -> free_count=0, in_ready=0 for rd writers; free_en reg 40 -> no bypass: accept next cycle, dest=40; bypass: accept same cycle, dest=40.
REQ-037 Reset with free_count=96 then free_en reg 50 -> free_overflow=1, free_count stays 96.
